mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Arbitrates a single line-wide (128-bit) memory port between the instruction cache and the data cache. It accepts one request at a time from either cache, drives the memory request/acknowledge handshake, captures the returned line and pulses a ready strobe back to the requester that owns the transaction. It sits between the ICache/DCache miss paths and main memory, replacing the direct ICache-to-memory connection.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on all ports
- LINE_W, 128, memory line width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ic_req  in  1  ICache read request; held high until ic_ready
- ic_addr  in  ADDR_W  ICache line address; stable while ic_req high
- ic_ready  out  1  one-cycle pulse: ICache transaction complete, ic_rdata valid
- ic_rdata  out  LINE_W  returned line for ICache
- dc_req  in  1  DCache request; held high until dc_ready
- dc_we  in  1  DCache write (1) / read (0); stable while dc_req high
- dc_addr  in  ADDR_W  DCache line address
- dc_wdata  in  LINE_W  DCache write line
- dc_ready  out  1  one-cycle pulse: DCache transaction complete
- dc_rdata  out  LINE_W  returned line for DCache
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address, bits [3:0] forced to 0
- mem_wdata  out  LINE_W  memory write data
- mem_ack  in  1  memory completion pulse; mem_rdata valid in the same cycle
- mem_rdata  in  LINE_W  memory read data
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when ic_req or dc_req is high at a rising edge, grant one, latch its addr/we/wdata into transaction registers, record owner, go to BUSY. With no request, stay in IDLE.
- Arbitration is round-robin on ties: if both are high, grant the one not recorded in last_grant; last_grant updates on every grant. last_grant resets to IC, so the first tie goes to DC. A single requester is always granted.
- ICache transactions are always reads (mem_we=0).
- BUSY: mem_req=1 and mem_addr/mem_we/mem_wdata come from the transaction registers, all held stable. On mem_ack, capture mem_rdata into the response register (also on writes) and go to RESP.
- RESP: pulse the owner's ready for exactly one cycle, then go to IDLE. The non-owner's ready stays 0.
- ic_rdata and dc_rdata both drive the shared response register. Data is valid only with the matching ready and holds until the next capture.
- mem_ack in IDLE or RESP is ignored.
- Requester obligation: drop req in the cycle after its ready. Req is sampled again in IDLE, so a requester that keeps req high gets a new transaction.
- Reset (any time, including mid-BUSY) has these effects:
  - state returns to IDLE and the in-flight transaction is dropped;
  - mem_req, mem_we, ic_ready, dc_ready and busy go to 0;
  - mem_addr, mem_wdata, ic_rdata and dc_rdata go to 0;
  - last_grant goes to IC.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from ic_req, dc_req or mem_ack to any output.
- A request sampled at edge 0 gives mem_req=1 from edge 0 to edge 1 (cycle 1).
- If mem_ack arrives in cycle k (k≥1), ready is high in cycle k+1. Minimum latency from request sample to ready is 2 cycles.
- Back-to-back: after RESP, one IDLE cycle always precedes the next mem_req. Throughput is one transaction per (mem latency + 2) cycles.
- A request arriving while busy waits. It is granted at the first IDLE edge at which it is high.

## Test plan
- Single ICache read:
  - stimulus: ic_req=1, ic_addr=0x0000_1234; memory acks 3 cycles after mem_req with 0xAAAA…;
  - required: mem_addr=0x0000_1230, mem_we=0, ic_ready pulses once 1 cycle after ack, ic_rdata=0xAAAA…, dc_ready=0.
- DCache write:
  - stimulus: dc_req=1, dc_we=1, dc_addr=0x80, dc_wdata=0x1122…;
  - required: mem_we=1, mem_wdata=0x1122…, dc_ready single pulse.
- Simultaneous requests from reset:
  - stimulus: ic_req and dc_req high together and held;
  - required: grants alternate DC, IC, DC, IC across four transactions; each ready goes only to its owner.
- Request arriving while BUSY:
  - stimulus: dc_req raised during an IC transaction;
  - required: DC is granted at the IDLE after the IC RESP; mem_req stays low for exactly 1 cycle between the two transactions.
- Reset mid-BUSY:
  - stimulus: assert reset while mem_req=1, then a late mem_ack;
  - required: mem_req=0 and busy=0 immediately; the late mem_ack produces no ready; the next ic_req is served normally.
- Stray acks:
  - stimulus: pulse mem_ack in IDLE and in RESP;
  - required: no state change, no extra ready, response register unchanged.

Source files
------------

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter
// Shares one line-wide memory port between the ICache and DCache miss paths.
// One transaction is in flight at a time. The IDLE -> BUSY -> RESP sequence
// runs the memory handshake and then returns a single-cycle ready pulse to
// whichever cache owns the transaction. Every output is either a register or
// is decoded from registered state, so no input has a combinational path to
// any output.

module mem_line_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clock,
   input  logic              reset,
   // ICache miss path (reads only)
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_ready,
   output logic [LINE_W-1:0] ic_rdata,
   // DCache miss / writeback path
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_ready,
   output logic [LINE_W-1:0] dc_rdata,
   // Memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Owner encoding, shared by owner_q and last_grant_q.
   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   // Memory is line-addressed: the byte offset inside a 16-byte line is cleared.
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

   state_e              state_q, state_d;
   logic                owner_q;
   logic                last_grant_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wdata_q;
   logic [LINE_W-1:0]   resp_q;

   logic                start_s;
   logic                grant_dc_s;
   logic                capture_s;
   logic [ADDR_W-1:0]   addr_sel_s;
   logic [LINE_W-1:0]   wdata_sel_s;
   logic                we_sel_s;

   // Grant decision: a lone requester always wins; on a tie the requester
   // that did not receive the previous grant wins.
   always_comb begin
      grant_dc_s  = 1'b0;
      addr_sel_s  = ic_addr;
      wdata_sel_s = {LINE_W{1'b0}};
      we_sel_s    = 1'b0;
      start_s     = (state_q == ST_IDLE) && (ic_req || dc_req);
      capture_s   = (state_q == ST_BUSY) && mem_ack;
      if (dc_req && (!ic_req || (last_grant_q == OWN_IC))) begin
         grant_dc_s  = 1'b1;
         addr_sel_s  = dc_addr;
         wdata_sel_s = dc_wdata;
         we_sel_s    = dc_we;
      end else begin
         // ICache wins (or nobody requests); ICache traffic is always a read.
         grant_dc_s  = 1'b0;
         addr_sel_s  = ic_addr;
         wdata_sel_s = {LINE_W{1'b0}};
         we_sel_s    = 1'b0;
      end
   end

   // Next-state logic for the transaction sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ic_req || dc_req) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Transaction registers: latched at grant and held stable through BUSY.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner_q      <= OWN_IC;
         last_grant_q <= OWN_IC;
         we_q         <= 1'b0;
         addr_q       <= {ADDR_W{1'b0}};
         wdata_q      <= {LINE_W{1'b0}};
      end else if (start_s) begin
         owner_q      <= grant_dc_s;
         last_grant_q <= grant_dc_s;
         we_q         <= we_sel_s;
         addr_q       <= addr_sel_s;
         wdata_q      <= wdata_sel_s;
      end
   end

   // Response register: captures returned data on every acknowledged
   // transaction (writes included); acks outside BUSY are ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_q <= {LINE_W{1'b0}};
      end else if (capture_s) begin
         resp_q <= mem_rdata;
      end
   end

   // Outputs decoded from registered state only.
   assign mem_req   = (state_q == ST_BUSY);
   assign mem_we    = (state_q == ST_BUSY) && we_q;
   assign mem_addr  = addr_q & LINE_MASK;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign ic_ready  = (state_q == ST_RESP) && (owner_q == OWN_IC);
   assign dc_ready  = (state_q == ST_RESP) && (owner_q == OWN_DC);
   assign ic_rdata  = resp_q;
   assign dc_rdata  = resp_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.

module tb_mem_line_arbiter;

   logic         clock = 1'b0;
   logic         reset;
   logic         ic_req;
   logic [31:0]  ic_addr;
   logic         ic_ready;
   logic [127:0] ic_rdata;
   logic         dc_req;
   logic         dc_we;
   logic [31:0]  dc_addr;
   logic [127:0] dc_wdata;
   logic         dc_ready;
   logic [127:0] dc_rdata;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_ack;
   logic [127:0] mem_rdata;
   logic         busy;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] PAT_A = {4{32'hAAAA_AAAA}};
   localparam logic [127:0] PAT_W = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
   localparam logic [127:0] PAT_5 = {4{32'h5555_5555}};
   localparam logic [127:0] PAT_D = {4{32'hDEAD_BEEF}};
   localparam logic [127:0] PAT_E = {4{32'h0E0E_0E0E}};
   localparam logic [127:0] PAT_F = {4{32'hFFFF_FFFF}};

   mem_line_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
      .clock     (clock),
      .reset     (reset),
      .ic_req    (ic_req),
      .ic_addr   (ic_addr),
      .ic_ready  (ic_ready),
      .ic_rdata  (ic_rdata),
      .dc_req    (dc_req),
      .dc_we     (dc_we),
      .dc_addr   (dc_addr),
      .dc_wdata  (dc_wdata),
      .dc_ready  (dc_ready),
      .dc_rdata  (dc_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Advance one full cycle: through the rising edge to the next falling edge.
   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset;
      reset = 1'b1; ic_req = 1'b0; ic_addr = 32'h0; dc_req = 1'b0; dc_we = 1'b0;
      dc_addr = 32'h0; dc_wdata = 128'h0; mem_ack = 1'b0; mem_rdata = 128'h0;
      @(negedge clock);
      tick;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({ic_ready, dc_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {ic_ready, dc_ready}); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      checks++; if (mem_wdata !== 128'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      checks++; if (ic_rdata !== 128'h0 || dc_rdata !== 128'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0", ic_rdata, dc_rdata); end
      reset = 1'b0;
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
   endtask

   task automatic test_ic_read;
      ic_req = 1'b1; ic_addr = 32'h0000_1234;
      tick;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ic_mem_req: got %b want 1", mem_req); end
      checks++; if (mem_addr !== 32'h0000_1230) begin errors++; $display("FAIL ic_mem_addr: got %h want 00001230", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ic_mem_we: got %b want 0", mem_we); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ic_busy: got %b want 1", busy); end
      tick; tick;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1230) begin errors++; $display("FAIL ic_hold: got req=%b addr=%h want 1/00001230", mem_req, mem_addr); end
      tick;
      mem_ack = 1'b1; mem_rdata = PAT_A;
      tick;
      mem_ack = 1'b0; mem_rdata = 128'h0;
      checks++; if (ic_ready !== 1'b1) begin errors++; $display("FAIL ic_ready_pulse: got %b want 1", ic_ready); end
      checks++; if (dc_ready !== 1'b0) begin errors++; $display("FAIL ic_dc_ready: got %b want 0", dc_ready); end
      checks++; if (ic_rdata !== PAT_A) begin errors++; $display("FAIL ic_rdata: got %h want %h", ic_rdata, PAT_A); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ic_resp_mem_req: got %b want 0", mem_req); end
      ic_req = 1'b0;
      tick;
      checks++; if (ic_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ic_after: got ready=%b busy=%b want 0/0", ic_ready, busy); end
      checks++; if (ic_rdata !== PAT_A) begin errors++; $display("FAIL ic_rdata_hold: got %h want %h", ic_rdata, PAT_A); end
   endtask

   task automatic test_dc_write;
      dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0080; dc_wdata = PAT_W;
      tick;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL dc_wr_req_we: got %b/%b want 1/1", mem_req, mem_we); end
      checks++; if (mem_wdata !== PAT_W) begin errors++; $display("FAIL dc_wr_wdata: got %h want %h", mem_wdata, PAT_W); end
      checks++; if (mem_addr !== 32'h0000_0080) begin errors++; $display("FAIL dc_wr_addr: got %h want 00000080", mem_addr); end
      mem_ack = 1'b1; mem_rdata = PAT_5;
      tick;
      mem_ack = 1'b0; mem_rdata = 128'h0;
      checks++; if (dc_ready !== 1'b1 || ic_ready !== 1'b0) begin errors++; $display("FAIL dc_wr_ready: got dc=%b ic=%b want 1/0", dc_ready, ic_ready); end
      checks++; if (dc_rdata !== PAT_5) begin errors++; $display("FAIL dc_wr_capture: got %h want %h", dc_rdata, PAT_5); end
      dc_req = 1'b0; dc_we = 1'b0;
      tick;
      checks++; if (dc_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL dc_wr_after: got ready=%b busy=%b we=%b want 0/0/0", dc_ready, busy, mem_we); end
   endtask

   task automatic test_round_robin;
      logic         exp_dc;
      logic [127:0] d;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      ic_addr = 32'h0000_1000; dc_addr = 32'h0000_2000; dc_we = 1'b0;
      ic_req = 1'b1; dc_req = 1'b1;
      tick;
      for (int i = 0; i < 4; i++) begin
         exp_dc = (i % 2 == 0);
         d = 128'h0; d[7:0] = 8'(i + 1); d[127:120] = 8'hC0;
         checks++; if (mem_addr !== (exp_dc ? 32'h0000_2000 : 32'h0000_1000)) begin errors++; $display("FAIL rr_grant_%0d: got addr %h want %h", i, mem_addr, exp_dc ? 32'h0000_2000 : 32'h0000_1000); end
         mem_ack = 1'b1; mem_rdata = d;
         tick;
         mem_ack = 1'b0; mem_rdata = 128'h0;
         checks++; if (dc_ready !== exp_dc || ic_ready !== !exp_dc) begin errors++; $display("FAIL rr_ready_%0d: got ic=%b dc=%b want ic=%b dc=%b", i, ic_ready, dc_ready, !exp_dc, exp_dc); end
         checks++; if (ic_rdata !== d) begin errors++; $display("FAIL rr_data_%0d: got %h want %h", i, ic_rdata, d); end
         if (i == 3) begin
            ic_req = 1'b0; dc_req = 1'b0;
         end
         tick;
         checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_gap_%0d: got req=%b busy=%b want 0/0", i, mem_req, busy); end
         tick;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_idle: got %b want 0", busy); end
   endtask

   task automatic test_busy_arrival;
      ic_req = 1'b1; ic_addr = 32'h0000_3000;
      tick;
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_5000;
      tick;
      checks++; if (mem_addr !== 32'h0000_3000 || mem_req !== 1'b1) begin errors++; $display("FAIL wait_ic_held: got addr=%h req=%b want 00003000/1", mem_addr, mem_req); end
      mem_ack = 1'b1; mem_rdata = PAT_5;
      tick;
      mem_ack = 1'b0;
      checks++; if (ic_ready !== 1'b1 || dc_ready !== 1'b0) begin errors++; $display("FAIL wait_ic_ready: got ic=%b dc=%b want 1/0", ic_ready, dc_ready); end
      ic_req = 1'b0;
      tick;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wait_gap: got %b want 0", mem_req); end
      tick;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5000) begin errors++; $display("FAIL wait_dc_grant: got req=%b addr=%h want 1/00005000", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = PAT_A;
      tick;
      mem_ack = 1'b0;
      checks++; if (dc_ready !== 1'b1 || ic_ready !== 1'b0 || dc_rdata !== PAT_A) begin errors++; $display("FAIL wait_dc_ready: got dc=%b ic=%b data=%h want 1/0/%h", dc_ready, ic_ready, dc_rdata, PAT_A); end
      dc_req = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_busy;
      ic_req = 1'b1; ic_addr = 32'h0000_0010;
      tick;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", mem_req); end
      reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: got req=%b busy=%b want 0/0", mem_req, busy); end
      checks++; if (ic_rdata !== 128'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", ic_rdata); end
      ic_req = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = PAT_F;
      tick;
      mem_ack = 1'b0; mem_rdata = 128'h0;
      checks++; if (ic_ready !== 1'b0 || dc_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got ic=%b dc=%b busy=%b want 0/0/0", ic_ready, dc_ready, busy); end
      tick;
      checks++; if (ic_ready !== 1'b0 || ic_rdata !== 128'h0) begin errors++; $display("FAIL rst_late_ack2: got ready=%b data=%h want 0/0", ic_ready, ic_rdata); end
      ic_req = 1'b1; ic_addr = 32'h4321_0008;
      tick;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4321_0000) begin errors++; $display("FAIL rst_next_req: got req=%b addr=%h want 1/43210000", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = PAT_D;
      tick;
      mem_ack = 1'b0; mem_rdata = 128'h0;
      checks++; if (ic_ready !== 1'b1 || ic_rdata !== PAT_D) begin errors++; $display("FAIL rst_next_ready: got ready=%b data=%h want 1/%h", ic_ready, ic_rdata, PAT_D); end
      ic_req = 1'b0;
      tick;
   endtask

   task automatic test_stray_acks;
      mem_ack = 1'b1; mem_rdata = PAT_F;
      tick;
      mem_ack = 1'b0; mem_rdata = 128'h0;
      checks++; if (busy !== 1'b0 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin errors++; $display("FAIL stray_idle_state: got busy=%b ic=%b dc=%b want 0/0/0", busy, ic_ready, dc_ready); end
      checks++; if (ic_rdata !== PAT_D) begin errors++; $display("FAIL stray_idle_data: got %h want %h", ic_rdata, PAT_D); end
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0700;
      tick;
      mem_ack = 1'b1; mem_rdata = PAT_E;
      tick;
      mem_ack = 1'b0;
      checks++; if (dc_ready !== 1'b1 || dc_rdata !== PAT_E) begin errors++; $display("FAIL stray_dc_ready: got ready=%b data=%h want 1/%h", dc_ready, dc_rdata, PAT_E); end
      dc_req = 1'b0;
      mem_ack = 1'b1; mem_rdata = PAT_F;
      tick;
      mem_ack = 1'b0; mem_rdata = 128'h0;
      checks++; if (busy !== 1'b0 || dc_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL stray_resp_state: got busy=%b ready=%b req=%b want 0/0/0", busy, dc_ready, mem_req); end
      checks++; if (dc_rdata !== PAT_E) begin errors++; $display("FAIL stray_resp_data: got %h want %h", dc_rdata, PAT_E); end
      tick;
      checks++; if (dc_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stray_final: got ready=%b busy=%b want 0/0", dc_ready, busy); end
   endtask

   initial begin
      test_reset;
      test_ic_read;
      test_dc_write;
      test_round_robin;
      test_busy_arrival;
      test_reset_mid_busy;
      test_stray_acks;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
